// File: rtl/fsk_pkg.sv
// -----------------------------------------------------------------------------
// fsk_pkg
// Shared types and constants for the FSK receiver frequency-measurement path.
//   meas_state_t : measurement controller FSM states
//   DIV_W        : divider operand / quotient width
//   DIV_LATENCY  : cycles from a divider start pulse to its done pulse
// -----------------------------------------------------------------------------
package fsk_pkg;

   localparam int unsigned DIV_W       = 32;
   localparam int unsigned DIV_LATENCY = 33;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StCount,
      StDivide,
      StPublish
   } meas_state_t;

endpackage

// File: rtl/period_divider.sv
// -----------------------------------------------------------------------------
// period_divider
// Iterative restoring divider, one quotient bit per cycle. A start pulse loads
// the operands; DIV_W iterations later quot holds num/den (truncated) and done
// pulses for one cycle, DIV_LATENCY cycles after start.
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   abort in   return to idle immediately, no done pulse
//   start in   load num/den and begin (ignored while busy)
//   num   in   dividend
//   den   in   divisor (must be non-zero)
//   done  out  one-cycle pulse when quot is valid
//   quot  out  quotient
// -----------------------------------------------------------------------------
module period_divider
   import fsk_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             abort,
   input  logic             start,
   input  logic [DIV_W-1:0] num,
   input  logic [DIV_W-1:0] den,
   output logic             done,
   output logic [DIV_W-1:0] quot
);

   localparam int unsigned IterW = $clog2(DIV_W);
   localparam logic [IterW-1:0] LastIter = IterW'(DIV_W - 1);

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [IterW-1:0] iter_q, iter_d;
   logic [DIV_W-1:0] rem_q, rem_d;
   logic [DIV_W-1:0] quot_q, quot_d;
   logic [DIV_W-1:0] den_q, den_d;
   logic [DIV_W:0]   rem_shift;
   logic [DIV_W:0]   rem_sub;

   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      iter_d = iter_q;
      rem_d  = rem_q;
      quot_d = quot_q;
      den_d  = den_q;
      // quot_q doubles as the dividend shift register during iteration
      rem_shift = {rem_q, quot_q[DIV_W-1]};
      rem_sub   = rem_shift - {1'b0, den_q};
      if (abort) begin
         busy_d = 1'b0;
      end else if (busy_q) begin
         // MSB of the difference set means it borrowed: keep the shifted remainder
         if (!rem_sub[DIV_W]) begin
            rem_d  = rem_sub[DIV_W-1:0];
            quot_d = {quot_q[DIV_W-2:0], 1'b1};
         end else begin
            rem_d  = rem_shift[DIV_W-1:0];
            quot_d = {quot_q[DIV_W-2:0], 1'b0};
         end
         iter_d = iter_q + 1'b1;
         if (iter_q == LastIter) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end else if (start) begin
         busy_d = 1'b1;
         iter_d = '0;
         rem_d  = '0;
         quot_d = num;
         den_d  = den;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         iter_q <= '0;
         rem_q  <= '0;
         quot_q <= '0;
         den_q  <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         iter_q <= iter_d;
         rem_q  <= rem_d;
         quot_q <= quot_d;
         den_q  <= den_d;
      end
   end

   assign done = done_q;
   assign quot = quot_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// -----------------------------------------------------------------------------
// freq_meas_ctrl
// Synchronizes the FSK demodulator square wave, times AVG_CYCLES input periods
// in clk cycles, divides CLOCK_FREQ*AVG_CYCLES by that count and publishes the
// frequency in Hz. Short periods are rejected as glitches; missing edges time
// out and publish 0.
//   clk        in   system clock (CLOCK_FREQ Hz)
//   rst        in   synchronous active-high reset
//   signal_in  in   asynchronous FSK square-wave input
//   enable     in   run measurements while high
//   freq_out   out  last published frequency in Hz
//   freq_valid out  one-cycle pulse when freq_out updates
//   timeout    out  one-cycle pulse when no period completes within the limit
//   busy       out  high in every state except idle
// -----------------------------------------------------------------------------
module freq_meas_ctrl
   import fsk_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 200000000,
   parameter int unsigned AVG_CYCLES = 2,
   parameter int unsigned MIN_PERIOD = 4,
   parameter int unsigned MAX_PERIOD = 16777216
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        signal_in,
   input  logic        enable,
   output logic [31:0] freq_out,
   output logic        freq_valid,
   output logic        timeout,
   output logic        busy
);

   localparam logic [DIV_W-1:0] DivNum   = DIV_W'(CLOCK_FREQ * AVG_CYCLES);
   localparam logic [31:0]      MinTotal = 32'(MIN_PERIOD * AVG_CYCLES);
   localparam logic [31:0]      CntLimit = 32'(MAX_PERIOD * AVG_CYCLES);
   localparam logic [4:0]       LastEdge = 5'(AVG_CYCLES - 1);

   logic        sync1_q, sync2_q, sync3_q;
   logic        rise;

   meas_state_t state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [4:0]  edges_q, edges_d;
   logic [31:0] total_q, total_d;
   logic        started_q, started_d;
   logic [31:0] freq_out_q, freq_out_d;
   logic        freq_valid_q, freq_valid_d;
   logic        timeout_q, timeout_d;

   logic        div_start;
   logic        div_abort;
   logic        div_done;
   logic [31:0] div_quot;

   // Fixed 3-cycle delay on every edge, so measured periods are unaffected
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= signal_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign rise = sync2_q & ~sync3_q;

   period_divider u_div (
      .clk   (clk),
      .rst   (rst),
      .abort (div_abort),
      .start (div_start),
      .num   (DivNum),
      .den   (total_q),
      .done  (div_done),
      .quot  (div_quot)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      edges_d      = edges_q;
      total_d      = total_q;
      started_d    = started_q;
      freq_out_d   = freq_out_q;
      freq_valid_d = 1'b0;
      timeout_d    = 1'b0;
      div_start    = 1'b0;
      div_abort    = 1'b0;

      // Disable wins over everything, including a coincident div_done
      if (state_q != StIdle && !enable) begin
         state_d   = StIdle;
         div_abort = 1'b1;
         started_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (enable) state_d = StArm;
            end
            StArm: begin
               if (rise) begin
                  cnt_d   = 32'd1;
                  edges_d = '0;
                  state_d = StCount;
               end
            end
            StCount: begin
               // Final edge on the limit cycle counts as completion
               if (rise && edges_q == LastEdge) begin
                  total_d   = cnt_q;
                  started_d = 1'b0;
                  state_d   = (cnt_q < MinTotal) ? StArm : StDivide;
               end else if (cnt_q >= CntLimit) begin
                  freq_out_d   = '0;
                  freq_valid_d = 1'b1;
                  timeout_d    = 1'b1;
                  state_d      = StArm;
               end else begin
                  cnt_d = cnt_q + 32'd1;
                  if (rise) edges_d = edges_q + 5'd1;
               end
            end
            StDivide: begin
               if (!started_q) begin
                  div_start = 1'b1;
                  started_d = 1'b1;
               end else if (div_done) begin
                  freq_out_d   = div_quot;
                  freq_valid_d = 1'b1;
                  state_d      = StPublish;
               end
            end
            StPublish: begin
               // Strobe is already out this cycle; re-arm for a fresh edge
               state_d = StArm;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         edges_q      <= '0;
         total_q      <= '0;
         started_q    <= 1'b0;
         freq_out_q   <= '0;
         freq_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         edges_q      <= edges_d;
         total_q      <= total_d;
         started_q    <= started_d;
         freq_out_q   <= freq_out_d;
         freq_valid_q <= freq_valid_d;
         timeout_q    <= timeout_d;
      end
   end

   assign freq_out   = freq_out_q;
   assign freq_valid = freq_valid_q;
   assign timeout    = timeout_q;
   assign busy       = (state_q != StIdle);

endmodule
